// File: rtl/uart_tx_serializer.sv
// UART transmit shifter: pops bytes from the TX FIFO and serializes each as one frame on TXD.
// Optional auto flow control is compiled in with `define UART_TX_AFC_EN (frame start gated by CTSN).
//
// state    | meaning
// S_IDLE   | no frame in progress; pops the FIFO when a byte is available
// S_START  | start bit (0) on the line
// S_DATA   | data bits, LSB first, WLS+5 of them
// S_PARITY | parity bit (only when PEN was set at pop time)
// S_STOP   | stop bits: 1, 1.5 or 2 bit times of 1
module uart_tx_serializer #(
    parameter int OSR = 16
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       BCLK,
    input  logic       TXF_EMPTY,
    input  logic [7:0] TXF_Q,
    output logic       TXF_READ,
    input  logic [1:0] WLS,
    input  logic       STB,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       SP,
    input  logic       BC,
    input  logic       CTSN,
    output logic       TXD,
    output logic       TXFINISHED
);

    localparam int CNT_W = $clog2(2 * OSR);
    localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(OSR - 1);
    localparam logic [CNT_W-1:0] STOP15_LAST = CNT_W'(OSR + OSR / 2 - 1);
    localparam logic [CNT_W-1:0] STOP2_LAST  = CNT_W'(2 * OSR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] tick_cnt, tick_cnt_nxt, tick_limit;
    logic [2:0]       bit_cnt, bit_cnt_nxt, bit_last;
    logic [7:0]       data_q, word_mask;
    logic [1:0]       wls_q;
    logic             stb_q, pen_q, eps_q, sp_q;
    logic             start_ok, load, line_bit, data_xor, parity_bit, tick_done;

`ifdef UART_TX_AFC_EN
    assign start_ok = ~CTSN;
`else
    logic unused_ctsn;
    assign unused_ctsn = CTSN;
    assign start_ok    = 1'b1;
`endif

    // Frame format comes only from the copies latched at pop time.
    assign word_mask  = 8'hFF >> (2'd3 - wls_q);
    assign data_xor   = ^(data_q & word_mask);
    assign parity_bit = sp_q ? ~eps_q : (eps_q ? data_xor : ~data_xor);
    assign bit_last   = {1'b0, wls_q} + 3'd4;

    always_comb begin
        tick_limit = BIT_LAST;
        if (state == S_STOP && stb_q)
            tick_limit = (wls_q == 2'b00) ? STOP15_LAST : STOP2_LAST;
    end

    assign tick_done = BCLK && (tick_cnt == tick_limit);

    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_cnt_nxt  = bit_cnt;
        load         = 1'b0;
        line_bit     = 1'b1;
        if (state != S_IDLE && BCLK)
            tick_cnt_nxt = tick_done ? '0 : tick_cnt + 1'b1;
        case (state)
            S_IDLE: begin
                tick_cnt_nxt = '0;
                bit_cnt_nxt  = '0;
                if (!TXF_EMPTY && start_ok) begin
                    load      = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                line_bit = 1'b0;
                if (tick_done)
                    state_nxt = S_DATA;
            end
            S_DATA: begin
                line_bit = data_q[bit_cnt];
                if (tick_done) begin
                    if (bit_cnt == bit_last) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = pen_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                line_bit = parity_bit;
                if (tick_done)
                    state_nxt = S_STOP;
            end
            S_STOP: begin
                if (tick_done)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            TXD        <= 1'b1;
            TXF_READ   <= 1'b0;
            TXFINISHED <= 1'b1;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            TXD        <= line_bit & ~BC;
            TXF_READ   <= load;
            TXFINISHED <= (state_nxt == S_IDLE);
        end
    end

    // FIFO head and flags are registered, so Q is valid in the same cycle the pop is decided.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            data_q <= '0;
            wls_q  <= '0;
            stb_q  <= 1'b0;
            pen_q  <= 1'b0;
            eps_q  <= 1'b0;
            sp_q   <= 1'b0;
        end else if (load) begin
            data_q <= TXF_Q;
            wls_q  <= WLS;
            stb_q  <= STB;
            pen_q  <= PEN;
            eps_q  <= EPS;
            sp_q   <= SP;
        end
    end

endmodule
